// File: rtl/rf_pkg.sv
// Shared types and helpers for the bypassed, scoreboarded register file.
package rf_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D   = $clog2(NREG_D);
  localparam int MAXREG = 256;

  typedef logic [AW_D-1:0] reg_addr_t;

  function automatic int unsigned popcount(
    input logic [MAXREG-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAXREG; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit tracking of in-flight writers with registered population count.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     pend_cnt,
  output logic            idle
);

  logic [NREG-1:0]   busy_nxt;
  logic [MAXREG-1:0] busy_ext;

  // Later assignments override earlier ones: flush > alloc > commit.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (alloc_en) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    busy_ext = '0;
    busy_ext[NREG-1:0] = busy_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
      idle     <= 1'b1;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= (AW+1)'(popcount(busy_ext));
      idle     <= (busy_nxt == '0);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file: NRP bypassed read ports plus writer scoreboard.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int AW   = $clog2(NREG),
  parameter int NRP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush,
  output logic [AW:0]       pend_cnt,
  output logic              idle
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy),
    .pend_cnt   (pend_cnt),
    .idle       (idle)
  );

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    logic [AW-1:0] addr;
    logic          match;
    logic          hit;

    assign addr  = rd_addr[i*AW +: AW];
    assign match = wr_en && (wr_addr == addr);
    assign hit   = rst_n && match && (addr != '0);

    assign rd_data[i*XLEN +: XLEN] = hit ? wr_data : mem[addr];
    assign rd_busy[i] = busy[addr] && !match;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic              clk;
  logic              rst_n;
  logic [NRP*AW-1:0] rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic              flush;
  logic [AW:0]       pend_cnt;
  logic              idle;

  int nchk;
  int nerr;

  regfile_sb #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW),
    .NRP  (NRP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .pend_cnt   (pend_cnt),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic idle_in();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle_in();
  endtask

  function automatic logic [31:0] d(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_addr = '0;
    idle_in();

    // 1: reset state across all addresses
    #2;
    for (int a = 0; a < NREG; a++) begin
      rd(a, NREG - 1 - a);
      #1;
      chk("rst_d0", d(0), 32'h0);
      chk("rst_d1", d(1), 32'h0);
      chk("rst_busy", 32'(rd_busy), 32'h0);
    end
    chk("rst_pend", 32'(pend_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: commit x5 with same-cycle bypass
    nxt();
    rd(5, 0);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    #1;
    chk("byp_x5", d(0), 32'hDEADBEEF);
    chk("byp_x5_busy", 32'(rd_busy[0]), 32'd0);
    nxt();
    #1;
    chk("arr_x5", d(0), 32'hDEADBEEF);
    chk("x5_nonbusy_pend", 32'(pend_cnt), 32'd0);
    nxt();
    rd(0, 5);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
    #1;
    chk("x0_byp", d(0), 32'h0);
    nxt();
    #1;
    chk("x0_arr", d(0), 32'h0);
    chk("x5_p1", d(1), 32'hDEADBEEF);

    // 3: alloc x7, then commit it
    nxt();
    rd(0, 7);
    alloc_en = 1'b1; alloc_addr = 7;
    #1;
    chk("x7_busy_early", 32'(rd_busy[1]), 32'd0);
    nxt();
    #1;
    chk("x7_busy", 32'(rd_busy[1]), 32'd1);
    chk("x7_pend", 32'(pend_cnt), 32'd1);
    chk("x7_idle", 32'(idle), 32'd0);
    nxt();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h700;
    #1;
    chk("x7_commit_busy", 32'(rd_busy[1]), 32'd0);
    chk("x7_commit_data", d(1), 32'h700);
    chk("x7_commit_pend", 32'(pend_cnt), 32'd1);
    nxt();
    #1;
    chk("x7_after_pend", 32'(pend_cnt), 32'd0);
    chk("x7_after_idle", 32'(idle), 32'd1);
    chk("x7_after_data", d(1), 32'h700);

    // 4: alloc wins over same-cycle commit
    nxt();
    rd(3, 0);
    alloc_en = 1'b1; alloc_addr = 3;
    nxt();
    alloc_en = 1'b1; alloc_addr = 3;
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
    #1;
    chk("x3_same_busy", 32'(rd_busy[0]), 32'd0);
    chk("x3_same_pend", 32'(pend_cnt), 32'd1);
    nxt();
    #1;
    chk("x3_data", d(0), 32'h55);
    chk("x3_busy", 32'(rd_busy[0]), 32'd1);
    chk("x3_pend", 32'(pend_cnt), 32'd1);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55;
    nxt();
    #1;
    chk("x3_release", 32'(pend_cnt), 32'd0);

    // alloc of x0 ignored
    nxt();
    rd(0, 0);
    alloc_en = 1'b1; alloc_addr = 0;
    nxt();
    #1;
    chk("x0_alloc_pend", 32'(pend_cnt), 32'd0);
    chk("x0_alloc_busy", 32'(rd_busy[0]), 32'd0);

    // 5: flush with same-cycle commit and alloc
    nxt();
    alloc_en = 1'b1; alloc_addr = 1;
    nxt();
    alloc_en = 1'b1; alloc_addr = 2;
    nxt();
    alloc_en = 1'b1; alloc_addr = 4;
    nxt();
    rd(1, 4);
    #1;
    chk("pre_flush_pend", 32'(pend_cnt), 32'd3);
    chk("pre_flush_busy", 32'(rd_busy), 32'b11);
    flush = 1'b1;
    wr_en = 1'b1; wr_addr = 2; wr_data = 32'hA5;
    alloc_en = 1'b1; alloc_addr = 9;
    nxt();
    rd(2, 9);
    #1;
    chk("flush_pend", 32'(pend_cnt), 32'd0);
    chk("flush_idle", 32'(idle), 32'd1);
    chk("flush_x2", d(0), 32'hA5);
    chk("flush_busy", 32'(rd_busy), 32'b00);
    rd(1, 4);
    #1;
    chk("flush_x14", 32'(rd_busy), 32'b00);

    // 6: asynchronous reset between edges
    nxt();
    wr_en = 1'b1; wr_addr = 6; wr_data = 32'h77;
    nxt();
    alloc_en = 1'b1; alloc_addr = 6;
    nxt();
    rd(6, 6);
    #1;
    chk("x6_data", d(0), 32'h77);
    chk("x6_busy", 32'(rd_busy), 32'b11);
    chk("x6_pend", 32'(pend_cnt), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_d0", d(0), 32'h0);
    chk("arst_d1", d(1), 32'h0);
    chk("arst_busy", 32'(rd_busy), 32'b00);
    chk("arst_pend", 32'(pend_cnt), 32'd0);
    chk("arst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
    #1;
    chk("post_rst_x5", d(0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the ID stage with write-to-read bypass on every read port and a per-register scoreboard that tracks in-flight writers. Decode allocates a destination at issue; writeback commits and releases it. Each read port reports whether its source is still pending so the hazard unit can stall. It replaces the fixed two-port, 32×32 bypassed register file.

## Interface

Parameters:

- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, $clog2(NREG), register address width
- NRP, 2, number of read ports (1..4)

Ports:

- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRP*XLEN  read data, with bypass applied
- rd_busy  out  NRP  source register still has a pending writer
- wr_en  in  1  writeback commit
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- alloc_en  in  1  issue-time destination allocation
- alloc_addr  in  AW  destination being allocated
- flush  in  1  discard all pending allocations (pipeline flush)
- pend_cnt  out  AW+1  number of registers currently marked busy
- idle  out  1  pend_cnt == 0

## Operation

- **Register x0:** reads 0 and is never busy. Writes and allocations to address 0 are ignored.
- **Read path (combinational):**
  - rd_data[i] = wr_data if wr_en, wr_addr == rd_addr[i] and rd_addr[i] != 0; otherwise the array contents.
  - rd_busy[i] = busy[rd_addr[i]] && !(wr_en && wr_addr == rd_addr[i]). A commit arriving in the same cycle clears the hazard.
- **Commit:** wr_en writes wr_data to the array at the next edge and clears busy[wr_addr].
  - A commit to a register that is not busy is legal: the data is written and busy stays clear.
- **Allocate:** alloc_en sets busy[alloc_addr] at the next edge.
  - Allocating an already-busy register is legal; the bit stays set. There is no writer counting: one commit releases the register.
- **Same-cycle alloc and commit, same address:** allocation wins, so busy ends set. The data is still written.
- **Flush:** clears every busy bit at the next edge.
  - A commit in the same cycle still writes its data.
  - An alloc in the same cycle is dropped.
  - Flush never alters array contents.
- **pend_cnt:** registered population count of the busy bits, updated with them. It never exceeds NREG-1.
- **Reset (asynchronous):** all array entries become 0 and all busy bits clear. pend_cnt = 0 and idle = 1. While reset is asserted, rd_data = 0 for every address, and rd_busy = 0 unless bypassed (rd_busy is never asserted in reset).

## Timing

- **Read latency:** 0 cycles, combinational from rd_addr, wr_*, and state.
- **Write-to-array latency:** 1 edge; bypass covers the cycle in between.
- **Busy update:** 1 edge after alloc_en, wr_en or flush. pend_cnt and idle change on the same edge.
- **Reset mid-operation:** takes effect immediately. Pending allocations are lost and no commit in that cycle is retained.
- **Priority per bit:** reset > flush > alloc > commit-clear.

## Structure

- **Shared package `rf_pkg`:** default XLEN/NREG constants, the reg-address typedef, and a `popcount` function.
- **Sub-module `rf_scoreboard`:** busy-bit vector, pend_cnt, and the alloc/commit/flush priority logic. regfile_sb instantiates the array, the NRP read muxes and the bypass compare around it.
- Generate loops are used over the NRP read ports.

## Test plan

1. Reset, then read all addresses on both ports → rd_data = 0, rd_busy = 0, idle = 1.
2. Commit x5 = 0xDEADBEEF while port 0 reads x5 in the same cycle → rd_data[0] = 0xDEADBEEF immediately and from the array on the next cycle. A commit to x0 of 0x1234 → x0 still reads 0.
3. Alloc x7, then port 1 reads x7 → rd_busy[1] = 1 and pend_cnt = 1. In the commit cycle rd_busy[1] = 0 and data is bypassed; the next cycle shows pend_cnt = 0 and idle = 1.
4. Alloc x3 and commit x3 = 0x55 in the same cycle while x3 is busy → next cycle x3 reads 0x55, busy[x3] = 1, pend_cnt unchanged.
5. Alloc x1, x2, x4, then flush together with commit x2 = 0xA5 and alloc x9 → next cycle pend_cnt = 0, x2 = 0xA5, x9 not busy.
6. Drop rst_n asynchronously between edges with x6 busy and holding 0x77 → x6 reads 0 and pend_cnt = 0 before the next edge.
